twiddle_loader: RTL

TWIDDLE_LOADER -- requirements
Module: twiddle_loader

---
 rtl/fft_pkg.sv | 16 +
 rtl/twiddle_loader.sv | 102 ++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// FFT-wide constants and the twiddle loader state encoding.
// Shared by the FFT blocks; DEPTH defaults come from here.
package fft_pkg;

   localparam int FFT_WORD_W   = 16;
   localparam int FFT_ADDR_W   = 16;
   localparam int FFT_TW_DEPTH = 256;

   typedef enum logic [1:0] {
      TW_IDLE   = 2'd0,
      TW_WRITE  = 2'd1,
      TW_VERIFY = 2'd2,
      TW_CHECK  = 2'd3
   } tw_state_t;

endpackage

// File: rtl/twiddle_loader.sv
// Streams DEPTH twiddle words into an external RAM, reads them back,
// and compares write-side and read-side sums to flag corruption.
module twiddle_loader
   import fft_pkg::*;
#(
   parameter int DEPTH = FFT_TW_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [FFT_WORD_W-1:0] s_data,
   output logic                  s_ready,
   output logic                  ram_we,
   output logic [FFT_ADDR_W-1:0] ram_addr,
   output logic [FFT_WORD_W-1:0] ram_wdata,
   input  logic [FFT_WORD_W-1:0] ram_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [FFT_WORD_W-1:0] checksum,
   output logic [1:0]            dbg_state
);

   // Handshake: a source word transfers on a rising edge where s_valid and
   // s_ready are both high; s_ready is high for every WRITE cycle.

   localparam int CNT_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   tw_state_t             state;
   logic [CNT_W-1:0]      cnt;
   logic [FFT_WORD_W-1:0] wsum;
   logic [FFT_WORD_W-1:0] rsum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TW_IDLE;
         cnt      <= '0;
         wsum     <= '0;
         rsum     <= '0;
         checksum <= '0;
         err      <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         // Abort wins over every other transition; it is a no-op when idle.
         if (abort && state != TW_IDLE) begin
            state <= TW_IDLE;
            err   <= 1'b1;
         end else begin
            case (state)
               TW_IDLE: begin
                  if (start) begin
                     state <= TW_WRITE;
                     cnt   <= '0;
                     wsum  <= '0;
                     rsum  <= '0;
                     err   <= 1'b0;
                  end
               end
               TW_WRITE: begin
                  if (s_valid) begin
                     wsum <= wsum + s_data;
                     if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= TW_VERIFY;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               TW_VERIFY: begin
                  rsum <= rsum + ram_rdata;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= TW_CHECK;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               TW_CHECK: begin
                  if (rsum != wsum) err <= 1'b1;
                  checksum <= wsum;
                  done     <= 1'b1;
                  state    <= TW_IDLE;
               end
               default: state <= TW_IDLE;
            endcase
         end
      end
   end

   assign s_ready   = (state == TW_WRITE);
   assign ram_we    = s_ready & s_valid;
   assign ram_addr  = (state == TW_WRITE || state == TW_VERIFY) ? FFT_ADDR_W'(cnt) : '0;
   assign ram_wdata = s_ready ? s_data : '0;
   assign busy      = (state != TW_IDLE);
   assign dbg_state = state;

endmodule
